pipelined_adder_tree: RTL



---
 rtl/pipelined_adder_tree.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipelined_adder_tree.sv
// Pipelined binary adder tree: sums 2**N_STAGE operands with one register rank per
// tree level and a valid/ready handshake that lets empty stages fill while stalled.
module pipelined_adder_tree #(
  parameter int N_STAGE = 5,
  parameter int IN_W    = 2,
  parameter int SIGNED  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [(2**N_STAGE)*IN_W-1:0] wx,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IN_W+N_STAGE-1:0]      y_out
);

  localparam int N_IN      = 2**N_STAGE;
  localparam int OUT_W     = IN_W + N_STAGE;
  localparam bit IS_SIGNED = (SIGNED != 0);

  // Level s holds N_IN>>s nodes of IN_W+s bits; all levels share one flat bus.
  function automatic int levelOff(input int s);
    int off;
    off = 0;
    for (int t = 0; t < s; t++) begin
      off += (N_IN >> t) * (IN_W + t);
    end
    return off;
  endfunction

  localparam int BUS_W = levelOff(N_STAGE) + OUT_W;

  wire  [BUS_W-1:0]   w_bus;
  logic [N_STAGE:1]   r_valid;
  logic [N_STAGE:1]   w_adv;
  logic [N_STAGE:0]   w_vchain;

  assign w_bus[N_IN*IN_W-1:0] = wx;
  assign w_vchain             = {r_valid, in_valid};

  // A stage may advance when downstream moves or any stage from here to the output is empty.
  always_comb begin
    w_adv = '0;
    for (int s = 1; s <= N_STAGE; s++) begin
      w_adv[s] = out_ready;
      for (int t = s; t <= N_STAGE; t++) begin
        if (!r_valid[t]) begin
          w_adv[s] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      for (int s = 1; s <= N_STAGE; s++) begin
        if (w_adv[s]) begin
          r_valid[s] <= w_vchain[s-1];
        end
      end
    end
  end

  for (genvar s = 1; s <= N_STAGE; s++) begin : g_level
    localparam int W     = IN_W + s;
    localparam int NODES = N_IN >> s;
    localparam int SRC   = levelOff(s - 1);
    localparam int DST   = levelOff(s);

    for (genvar k = 0; k < NODES; k++) begin : g_node
      logic [W-2:0] w_a;
      logic [W-2:0] w_b;
      logic [W-1:0] w_sum;
      logic [W-1:0] r_sum;

      assign w_a   = w_bus[SRC + (2*k)*(W-1) +: W-1];
      assign w_b   = w_bus[SRC + (2*k+1)*(W-1) +: W-1];
      // One guard bit per level makes overflow impossible.
      assign w_sum = {IS_SIGNED & w_a[W-2], w_a} + {IS_SIGNED & w_b[W-2], w_b};

      // Flush only kills the valid bits; the data simply holds.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sum <= '0;
        end else if (w_adv[s] && !flush) begin
          r_sum <= w_sum;
        end
      end

      assign w_bus[DST + k*W +: W] = r_sum;
    end
  end

  assign in_ready  = w_adv[1];
  assign out_valid = w_vchain[N_STAGE];
  assign y_out     = w_bus[BUS_W-1 -: OUT_W];

endmodule
